mem_bus_arbiter: RTL

- N-master to 1-slave arbiter for the word-addressed memory bus (addr/dataD/dataQ/read/write/ready/byteSel protocol).
- Sits between the pipeline's memory ports (I-fetch, LSU, debug/DMA) and the single cache/memory slave.
- Round-robin grant, one outstanding transaction, parametrised master count and address/data width.

---
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin N-master to 1-slave arbiter for the word-addressed
// memory bus, with one outstanding transaction at a time.
// Optional feature: define MEM_BUS_ARB_TIMEOUT_EN to abort a BUSY transaction
// after TIMEOUT cycles without s_ready. The abort completes the transaction with err=1.
module mem_bus_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 30,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned SEL_W    = DATA_W / 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS*ADDR_W-1:0]    m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]    m_dataD,
    output logic [N_MASTERS*DATA_W-1:0]    m_dataQ,
    input  logic [N_MASTERS-1:0]           m_read,
    input  logic [N_MASTERS-1:0]           m_write,
    output logic [N_MASTERS-1:0]           m_ready,
    input  logic [N_MASTERS*SEL_W-1:0]     m_byteSel,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_dataD,
    input  logic [DATA_W-1:0]              s_dataQ,
    output logic                           s_read,
    output logic                           s_write,
    input  logic                           s_ready,
    output logic [SEL_W-1:0]               s_byteSel,
    output logic [N_MASTERS-1:0]           grant,
    output logic                           busy,
    output logic                           err
);

    localparam int unsigned PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    // Elaboration-time sanity check of the configuration
    if (N_MASTERS < 2 || DATA_W == 0 || (DATA_W % 8) != 0 || TIMEOUT == 0) begin : g_param_check
        $error("mem_bus_arbiter: illegal parameter combination");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       g_idx;
    logic [N_MASTERS-1:0]   req;
    logic                   pick_any;
    logic [PTR_W-1:0]       pick_idx;
    logic [PTR_W-1:0]       scan_idx;
    logic [N_MASTERS-1:0]   pick_oh;
    logic                   req_g;
    logic                   rd_g;
    logic                   wr_g;
    logic                   timeout_c;
    logic [PTR_W-1:0]       rr_next;

    assign req     = m_read | m_write;
    assign req_g   = |(req & grant);
    assign rd_g    = |(m_read & grant);
    assign wr_g    = |(m_write & grant);
    assign busy    = (state == BUSY);
    assign m_dataQ = {N_MASTERS{s_dataQ}};
    assign rr_next = PTR_W'((32'(g_idx) + 32'd1) % N_MASTERS);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    // s_ready in the same cycle wins over the abort
    assign timeout_c = (state == BUSY) && !s_ready && (to_cnt == CNT_W'(TIMEOUT));

    // Watchdog: cleared on BUSY entry, counts BUSY cycles without s_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (!s_ready) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Round-robin pick: first requester scanning upward from rr_ptr with wrap
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 0; k < int'(N_MASTERS); k++) begin
            scan_idx = PTR_W'((32'(rr_ptr) + 32'(k)) % N_MASTERS);
            if (!pick_any && req[scan_idx]) begin
                pick_any = 1'b1;
                pick_idx = scan_idx;
            end
        end
        pick_oh = N_MASTERS'(pick_any) << pick_idx;
    end

    // Arbiter state: grant in IDLE, release on completion, drop or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            g_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= BUSY;
                        grant <= pick_oh;
                        g_idx <= pick_idx;
                    end
                end
                BUSY: begin
                    if (s_ready || !req_g || timeout_c) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= rr_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Slave-side mux from the owner and master completion flags
    always_comb begin
        s_addr    = '0;
        s_dataD   = '0;
        s_byteSel = '0;
        s_read    = 1'b0;
        s_write   = 1'b0;
        m_ready   = '0;
        err       = 1'b0;
        if (state == BUSY) begin
            for (int i = 0; i < int'(N_MASTERS); i++) begin
                if (grant[i]) begin
                    s_addr    = m_addr[i*ADDR_W +: ADDR_W];
                    s_dataD   = m_dataD[i*DATA_W +: DATA_W];
                    s_byteSel = m_byteSel[i*SEL_W +: SEL_W];
                end
            end
            s_write = wr_g;
            s_read  = rd_g & ~wr_g;
            m_ready = grant & {N_MASTERS{s_ready}};
            if (timeout_c) begin
                s_read  = 1'b0;
                s_write = 1'b0;
                m_ready = grant;
                err     = 1'b1;
            end
        end
    end

endmodule
